dff_counter_slice: RTL and testbench

//  Parametrised register slice for the qlf_k6n10f cell library: WIDTH flops sharing one clock, enable, sync reset and sync set.

---
 rtl/qlf_slice_pkg.sv | 14 +
 rtl/slice_carry_cell.sv | 14 +
 rtl/dff_counter_slice.sv | 118 +++++++++++
 tb/tb_dff_counter_slice.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/qlf_slice_pkg.sv
// Shared definitions for the qlf_k6n10f register slice: operation encoding
// and the largest slice width the carry chain model is meant for.
package qlf_slice_pkg;

  localparam int SLICE_MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    SLICE_HOLD  = 2'b00,
    SLICE_SHIFT = 2'b01,
    SLICE_UP    = 2'b10,
    SLICE_DOWN  = 2'b11
  } slice_mode_e;

endpackage

// File: rtl/slice_carry_cell.sv
// One bit of the slice's ripple chain, same function as the library carry
// cell: propagate selects between carry-in and generate.
module slice_carry_cell (
  input  logic p,
  input  logic g,
  input  logic cin,
  output logic sumout,
  output logic cout
);

  assign sumout = p ^ cin;
  assign cout   = p ? cin : g;

endmodule

// File: rtl/dff_counter_slice.sv
// WIDTH-bit register slice: register, shift register or up/down counter
// built on a per-bit carry chain. Sync reset/set, clock enable, parallel load.
// Build option: define QLF_SLICE_SATURATE_EN to make UP/DOWN stop at the
// bounds (CO held high on every blocked step) instead of wrapping.
// Intended for WIDTH in 1..SLICE_MAX_WIDTH.
module dff_counter_slice
  import qlf_slice_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] INIT    = '0,
  parameter logic [WIDTH-1:0] SET_VAL = '1
) (
  input  logic             C,
  input  logic             R,
  input  logic             S,
  input  logic             E,
  input  logic             L,
  input  logic [1:0]       MODE,
  input  logic [WIDTH-1:0] D,
  input  logic             SI,
  output logic [WIDTH-1:0] Q,
  output logic             SO,
  output logic             CO
);

  slice_mode_e      mode_dec;
  logic             is_down;
  logic [WIDTH-1:0] p_vec;
  logic [WIDTH-1:0] g_vec;
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] q_next;
  logic             co_next;

  assign mode_dec = slice_mode_e'(MODE);
  assign is_down  = (mode_dec == SLICE_DOWN);

  // UP adds zero with carry-in 1; DOWN adds all-ones with carry-in 0.
  // With b = 0 or all-ones, p = q ^ b and g = q & b.
  assign p_vec    = Q ^ {WIDTH{is_down}};
  assign g_vec    = Q & {WIDTH{is_down}};
  assign carry[0] = ~is_down;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_chain
      slice_carry_cell u_cell (
        .p      (p_vec[i]),
        .g      (g_vec[i]),
        .cin    (carry[i]),
        .sumout (sum[i]),
        .cout   (carry[i+1])
      );
    end
  endgenerate

  // Truncating cast keeps this valid for WIDTH=1 (Q <= SI).
  assign shifted = WIDTH'({Q, SI});

  // Next-state mux in priority order: R > S > !E > L > MODE.
  always_comb begin
    q_next  = Q;
    co_next = 1'b0;
    if (R) begin
      q_next = INIT;
    end else if (S) begin
      q_next = SET_VAL;
    end else if (!E) begin
      q_next = Q;
    end else if (L) begin
      q_next = D;
    end else begin
      unique case (mode_dec)
        SLICE_HOLD:  q_next = Q;
        SLICE_SHIFT: q_next = shifted;
        SLICE_UP: begin
          // Top carry-out is 1 exactly when Q is all-ones.
`ifdef QLF_SLICE_SATURATE_EN
          if (carry[WIDTH]) begin
            q_next  = Q;
            co_next = 1'b1;
          end else begin
            q_next  = sum;
          end
`else
          q_next  = sum;
          co_next = carry[WIDTH];
`endif
        end
        SLICE_DOWN: begin
          // Top carry-out is 0 exactly when Q is zero (borrow).
`ifdef QLF_SLICE_SATURATE_EN
          if (!carry[WIDTH]) begin
            q_next  = Q;
            co_next = 1'b1;
          end else begin
            q_next  = sum;
          end
`else
          q_next  = sum;
          co_next = ~carry[WIDTH];
`endif
        end
        default: q_next = Q;
      endcase
    end
  end

  // Q and CO registers; reset is folded into the next-state mux.
  always_ff @(posedge C) begin
    Q  <= q_next;
    CO <= co_next;
  end

  assign SO = Q[WIDTH-1];

endmodule

// File: tb/tb_dff_counter_slice.sv
// Directed bench for dff_counter_slice: an 8-bit slice (INIT=8'h5A) and a
// 1-bit slice. Expectations follow the build selected by QLF_SLICE_SATURATE_EN.
module tb_dff_counter_slice;

  // ---- clock / reset block ----
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // 8-bit slice
  logic       r, s, e, l, si;
  logic [1:0] mode;
  logic [7:0] d, q;
  logic       so, co;

  // 1-bit slice
  logic       r1, s1, e1, l1, si1;
  logic [1:0] mode1;
  logic [0:0] d1, q1;
  logic       so1, co1;

  dff_counter_slice #(.WIDTH(8), .INIT(8'h5A), .SET_VAL(8'hFF)) dut8 (
    .C(clk), .R(r), .S(s), .E(e), .L(l), .MODE(mode), .D(d), .SI(si),
    .Q(q), .SO(so), .CO(co)
  );

  dff_counter_slice #(.WIDTH(1)) dut1 (
    .C(clk), .R(r1), .S(s1), .E(e1), .L(l1), .MODE(mode1), .D(d1), .SI(si1),
    .Q(q1), .SO(so1), .CO(co1)
  );

  // ---- driver tasks ----
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    r = 1'b1; s = 1'b0; e = 1'b1; l = 1'b0; si = 1'b0; mode = 2'b10; d = 8'h00;
    r1 = 1'b1; s1 = 1'b0; e1 = 1'b0; l1 = 1'b0; si1 = 1'b0; mode1 = 2'b10; d1 = 1'b0;

    // Reset with E=1, MODE=UP: reset wins.
    step();
    check("rst_q", q, 8'h5A);
    check("rst_co", co, 0);
    check("rst_so", so, 0);
    check("rst_q1", q1, 0);
    check("rst_co1", co1, 0);
    r = 1'b0; r1 = 1'b0;

    // Load FE, then count up three times.
    l = 1'b1; d = 8'hFE;
    step();
    check("load_fe", q, 8'hFE);
    l = 1'b0; mode = 2'b10;
    step();
    check("up1_q", q, 8'hFF);
    check("up1_co", co, 0);
    check("up1_so", so, 1);
    step();
`ifdef QLF_SLICE_SATURATE_EN
    check("up2_q", q, 8'hFF);
    check("up2_co", co, 1);
    step();
    check("up3_q", q, 8'hFF);
    check("up3_co", co, 1);
`else
    check("up2_q", q, 8'h00);
    check("up2_co", co, 1);
    step();
    check("up3_q", q, 8'h01);
    check("up3_co", co, 0);
`endif

    // Load 00, then count down twice.
    l = 1'b1; d = 8'h00;
    step();
    check("load_00", q, 8'h00);
    check("load_co", co, 0);
    l = 1'b0; mode = 2'b11;
    step();
`ifdef QLF_SLICE_SATURATE_EN
    check("dn1_q", q, 8'h00);
    check("dn1_co", co, 1);
    step();
    check("dn2_q", q, 8'h00);
    check("dn2_co", co, 1);
`else
    check("dn1_q", q, 8'hFF);
    check("dn1_co", co, 1);
    step();
    check("dn2_q", q, 8'hFE);
    check("dn2_co", co, 0);
`endif

    // Shift from 81 with SI=0 then SI=1.
    l = 1'b1; d = 8'h81;
    step();
    check("load_81_so", so, 1);
    l = 1'b0; mode = 2'b01; si = 1'b0;
    step();
    check("sh1_q", q, 8'h02);
    check("sh1_so", so, 0);
    check("sh1_co", co, 0);
    si = 1'b1;
    step();
    check("sh2_q", q, 8'h05);
    check("sh2_co", co, 0);

    // Priority: R over S and L, S over L, !E over L.
    r = 1'b1; s = 1'b1; l = 1'b1; d = 8'h33;
    step();
    check("prio_r", q, 8'h5A);
    r = 1'b0;
    step();
    check("prio_s", q, 8'hFF);
    check("prio_s_co", co, 0);
    s = 1'b0; e = 1'b0;
    step();
    check("prio_hold", q, 8'hFF);

    // E=0 blocks counting too.
    mode = 2'b10; l = 1'b0;
    step();
    check("en_hold", q, 8'hFF);
    check("en_hold_co", co, 0);

    // Mid-count reset.
    e = 1'b1; r = 1'b1;
    step();
    check("mid_rst", q, 8'h5A);
    r = 1'b0;

    // 1-bit slice: UP toggles and marks the 1->0 wrap.
    e1 = 1'b1; mode1 = 2'b10;
    step();
    check("w1_up1_q", q1, 1);
    check("w1_up1_co", co1, 0);
    check("w1_up1_so", so1, 1);
    step();
`ifdef QLF_SLICE_SATURATE_EN
    check("w1_up2_q", q1, 1);
`else
    check("w1_up2_q", q1, 0);
`endif
    check("w1_up2_co", co1, 1);

    // 1-bit slice: SHIFT copies SI.
    mode1 = 2'b01; si1 = 1'b0;
    step();
    check("w1_sh0", q1, 0);
    check("w1_sh0_co", co1, 0);
    si1 = 1'b1;
    step();
    check("w1_sh1", q1, 1);

    // ---- final report ----
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
